end_screen_mover: RTL

END_SCREEN_MOVER -- requirements
Module: end_screen_mover

---
 rtl/end_screen_mover_pkg.sv | 15 +
 rtl/frame_counter.sv | 37 +++
 rtl/end_screen_mover.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/end_screen_mover_pkg.sv
// Shared VGA definitions: banner geometry and end-screen state encoding,
// used by end_screen_mover and the banner bitmap block.
package end_screen_mover_pkg;

    localparam int unsigned BANNER_W = 32;
    localparam int unsigned BANNER_H = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLIDE,
        ST_HOLD,
        ST_SHOW
    } es_state_e;

endpackage

// File: rtl/frame_counter.sv
// Frame pulse counter: counts enable pulses, flags the TERMINAL-th pulse
// combinationally and wraps to zero on it; clear has priority.
module frame_counter #(
    parameter int unsigned TERMINAL = 60
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] count_q, count_d;

    assign tc_o = enable_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/end_screen_mover.sv
// End-screen banner mover: slides a 32x32 banner down to its target, holds it,
// then shows it (blinking when END_SCREEN_BLINK_EN is defined).
module end_screen_mover
    import end_screen_mover_pkg::*;
#(
    parameter logic [10:0] TARGET_X     = 11'd304,
    parameter logic [10:0] TARGET_Y     = 11'd224,
    parameter logic [10:0] START_Y      = 11'd0,
    parameter int unsigned SLIDE_STEP   = 2,
    parameter int unsigned HOLD_FRAMES  = 60,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        gameOver,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        done
);

    if (START_Y > TARGET_Y || SLIDE_STEP == 0 || HOLD_FRAMES == 0 || BLINK_FRAMES == 0) begin : g_bad_params
        $error("end_screen_mover: illegal parameter set");
    end

    es_state_e   state_q, state_d;
    logic [10:0] top_y_q, top_y_d;
    logic        go_prev_q;
    logic        visible;
    logic        hold_tc;
    logic        sof_live;

    logic [11:0] y_sum, y_next;
    assign y_sum  = {1'b0, top_y_q} + 12'(SLIDE_STEP);
    assign y_next = (y_sum >= {1'b0, TARGET_Y}) ? {1'b0, TARGET_Y} : y_sum;

    assign sof_live = startOfFrame && gameOver;

    frame_counter #(.TERMINAL(HOLD_FRAMES)) u_hold_cnt (
        .clk_i    (clk),
        .rst_n_i  (resetN),
        .clear_i  (state_q != ST_HOLD),
        .enable_i (sof_live && (state_q == ST_HOLD)),
        .tc_o     (hold_tc)
    );

    always_comb begin
        state_d = state_q;
        top_y_d = top_y_q;
        if (!gameOver) begin
            state_d = ST_IDLE;
            top_y_d = START_Y;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    top_y_d = START_Y;
                    if (!go_prev_q) state_d = ST_SLIDE;
                end
                ST_SLIDE: begin
                    if (startOfFrame) begin
                        top_y_d = y_next[10:0];
                        if (y_next == {1'b0, TARGET_Y}) state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_tc) state_d = ST_SHOW;
                end
                ST_SHOW: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            top_y_q   <= START_Y;
            go_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            top_y_q   <= top_y_d;
            go_prev_q <= gameOver;
        end
    end

`ifdef END_SCREEN_BLINK_EN
    logic visible_q, visible_d, blink_tc;

    frame_counter #(.TERMINAL(BLINK_FRAMES)) u_blink_cnt (
        .clk_i    (clk),
        .rst_n_i  (resetN),
        .clear_i  (state_q != ST_SHOW),
        .enable_i (sof_live && (state_q == ST_SHOW)),
        .tc_o     (blink_tc)
    );

    always_comb begin
        visible_d = visible_q;
        if (!gameOver || state_q != ST_SHOW) begin
            visible_d = 1'b1;
        end else if (blink_tc) begin
            visible_d = ~visible_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) visible_q <= 1'b1;
        else         visible_q <= visible_d;
    end

    assign visible = visible_q;
`else
    assign visible = 1'b1;
`endif

    logic [11:0] px, py, x_lo, x_hi, y_lo, y_hi;
    logic        inside_d;
    logic [10:0] off_x_d, off_y_d;

    assign px   = {1'b0, pixelX};
    assign py   = {1'b0, pixelY};
    assign x_lo = {1'b0, TARGET_X};
    assign x_hi = x_lo + 12'(BANNER_W);
    assign y_lo = {1'b0, top_y_q};
    assign y_hi = y_lo + 12'(BANNER_H);

    // gameOver gating blanks the banner on the same edge that forces IDLE
    assign inside_d = gameOver && (state_q != ST_IDLE) && visible &&
                      (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
    assign off_x_d  = inside_d ? (pixelX - TARGET_X) : '0;
    assign off_y_d  = inside_d ? (pixelY - top_y_q)  : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offsetX         <= '0;
            offsetY         <= '0;
            InsideRectangle <= 1'b0;
        end else begin
            offsetX         <= off_x_d;
            offsetY         <= off_y_d;
            InsideRectangle <= inside_d;
        end
    end

    assign done = (state_q == ST_HOLD) || (state_q == ST_SHOW);

endmodule
